// File: rtl/word_triple_framer.sv
// word_triple_framer
//   Streaming wrapper around an external combinational W-bit bitwise stage.
//   Groups an input byte stream into (a, b, c) triples and presents each triple on
//   registered operand ports. The stage result is captured into a 2-entry output FIFO
//   that is read through a valid/ready interface.
//
// Parameters
//   W        byte width, equal to the bitwise stage width
//   TIMEOUT  idle cycles before a partial triple is dropped (1..65535); only used when
//            the macro WORD_FRAMER_TIMEOUT_EN is defined
//
// Build option
//   WORD_FRAMER_TIMEOUT_EN  enables the idle timeout on partial triples. When undefined,
//                           partial triples wait indefinitely and drop only comes from s_sof.
//
// Ports
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   s_valid/s_ready       input byte handshake
//   s_data, s_sof         input byte and start-of-frame marker
//   op_a, op_b, op_c      registered operands to the bitwise stage
//   op_res                combinational result from the bitwise stage
//   m_valid/m_ready       result handshake, m_data is the FIFO head
//   frame_cnt             number of results pushed into the FIFO (wraps)
//   drop                  one-cycle pulse when a partial triple is discarded

module word_triple_framer #(
    parameter int unsigned W       = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    input  logic         s_sof,
    output logic [W-1:0] op_a,
    output logic [W-1:0] op_b,
    output logic [W-1:0] op_c,
    input  logic [W-1:0] op_res,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data,
    output logic [15:0]  frame_cnt,
    output logic         drop
);

    typedef enum logic [1:0] {StC0, StC1, StC2, StCalc} state_e;

    state_e       state;
    logic         accept;
    logic         timeout;
    logic         push;
    logic         pop;
    logic [1:0]   fifo_cnt;
    logic [W-1:0] fifo_head;
    logic [W-1:0] fifo_tail;

    assign s_ready = (state != StCalc);
    assign accept  = s_valid && s_ready;

    assign m_valid = (fifo_cnt != 2'd0);
    assign m_data  = fifo_head;
    assign pop     = m_valid && m_ready;
    // A full FIFO can still take the result when its head leaves in the same cycle.
    assign push    = (state == StCalc) && ((fifo_cnt != 2'd2) || pop);

`ifdef WORD_FRAMER_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

    logic [15:0] idle_cnt;
    logic        in_partial;

    assign in_partial = (state == StC1) || (state == StC2);
    assign timeout    = in_partial && !accept && (idle_cnt == TimeoutLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= 16'd0;
        end else if (!in_partial || accept || timeout) begin
            idle_cnt <= 16'd0;
        end else begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end
`else
    // TIMEOUT has no effect in this build.
    assign timeout = (TIMEOUT == 0) && 1'b0;
`endif

    // Triple collection FSM with its registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StC0;
            op_a      <= '0;
            op_b      <= '0;
            op_c      <= '0;
            frame_cnt <= 16'd0;
            drop      <= 1'b0;
        end else begin
            drop <= 1'b0;
            case (state)
                StC0: begin
                    if (accept) begin
                        op_a  <= s_data;
                        state <= StC1;
                    end
                end
                StC1: begin
                    if (accept) begin
                        if (s_sof) begin
                            op_a  <= s_data;
                            drop  <= 1'b1;
                        end else begin
                            op_b  <= s_data;
                            state <= StC2;
                        end
                    end else if (timeout) begin
                        drop  <= 1'b1;
                        state <= StC0;
                    end
                end
                StC2: begin
                    if (accept) begin
                        if (s_sof) begin
                            op_a  <= s_data;
                            drop  <= 1'b1;
                            state <= StC1;
                        end else begin
                            op_c  <= s_data;
                            state <= StCalc;
                        end
                    end else if (timeout) begin
                        drop  <= 1'b1;
                        state <= StC0;
                    end
                end
                StCalc: begin
                    if (push) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= StC0;
                    end
                end
                default: state <= StC0;
            endcase
        end
    end

    // Two-entry result FIFO kept as head/tail registers so m_data is always a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_cnt  <= 2'd0;
            fifo_head <= '0;
            fifo_tail <= '0;
        end else begin
            case (fifo_cnt)
                2'd0: begin
                    if (push) begin
                        fifo_head <= op_res;
                        fifo_cnt  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        fifo_head <= op_res;
                    end else if (push) begin
                        fifo_tail <= op_res;
                        fifo_cnt  <= 2'd2;
                    end else if (pop) begin
                        fifo_cnt  <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        fifo_head <= fifo_tail;
                        if (push) begin
                            fifo_tail <= op_res;
                        end else begin
                            fifo_cnt <= 2'd1;
                        end
                    end
                end
                default: fifo_cnt <= 2'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_word_triple_framer.sv
// Testbench for word_triple_framer: directed scenarios plus randomized byte streams,
// results checked by a scoreboard monitor against a byte-stream reference model.

module tb_word_triple_framer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [W-1:0] s_data = '0;
    logic         s_sof = 1'b0;
    logic [W-1:0] op_a, op_b, op_c, op_res;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [W-1:0] m_data;
    logic [15:0]  frame_cnt;
    logic         drop;

    int           tests = 0;
    int           fails = 0;
    logic [7:0]   exp_q[$];
    logic [7:0]   part[3];
    int           part_n = 0;
    int           exp_drops = 0;
    int           drop_seen = 0;
    logic [15:0]  exp_frames = 16'd0;
    bit           rand_ready = 1'b0;
    bit           done = 1'b0;

    // Bit-by-bit evaluation of the stage rule.
    function automatic logic [7:0] stage_ref(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            bit t1, t2;
            t1 = (a[i] && b[i]) != c[i];
            t2 = (!a[i] && !b[i]) == c[i];
            r[i] = t1 || t2;
        end
        return r;
    endfunction

    // External bitwise stage.
    assign op_res = stage_ref(op_a, op_b, op_c);

    word_triple_framer #(.W(W), .TIMEOUT(255)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_sof     (s_sof),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_c      (op_c),
        .op_res    (op_res),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .frame_cnt (frame_cnt),
        .drop      (drop)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a triple is any three consecutive accepted bytes; sof on a byte
    // that arrives after a partial triple discards that partial triple.
    task automatic model_accept(input logic [7:0] d, input bit sof);
        if (sof && part_n > 0) begin
            exp_drops++;
            part_n = 0;
        end
        part[part_n] = d;
        part_n++;
        if (part_n == 3) begin
            exp_q.push_back(stage_ref(part[0], part[1], part[2]));
            exp_frames = exp_frames + 16'd1;
            part_n = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_byte(input logic [7:0] d, input bit sof);
        bit acc = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_ready) begin
                acc = 1'b1;
                break;
            end
            tick();
        end
        if (acc) begin
            model_accept(d, sof);
            tick();
        end else begin
            tests++;
            fails++;
            $display("FAIL send_timeout: byte %0h never accepted", d);
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
        end
        tick();
        tick();
    endtask

    task automatic monitor();
        bit         prev_v = 1'b0;
        bit         prev_r = 1'b0;
        logic [7:0] prev_d = '0;
        while (!done) begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (prev_v && !prev_r) begin
                    check("stall_hold_valid", 32'(m_valid), 32'd1);
                    check("stall_hold_data", 32'(m_data), 32'(prev_d));
                end
                if (drop) drop_seen++;
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_result: got %0h, expected no output", m_data);
                    end else begin
                        check("result", 32'(m_data), 32'(exp_q.pop_front()));
                    end
                end
                prev_v = m_valid;
                prev_r = m_ready;
                prev_d = m_data;
            end
        end
    endtask

    task automatic run();
        int d0, e0;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);
        check("rst_op_a", 32'(op_a), 32'd0);
        rst_n = 1'b1;
        tick();

        // T1: single triple and latency
        m_ready = 1'b1;
        send_byte(8'hF0, 1'b0);
        send_byte(8'hCC, 1'b0);
        send_byte(8'hAA, 1'b0);
        check("t1_op_c", 32'(op_c), 32'hAA);
        check("t1_not_early", 32'(m_valid), 32'd0);
        tick();
        check("t1_m_valid", 32'(m_valid), 32'd1);
        check("t1_m_data", 32'(m_data), 32'h7E);
        tick();
        check("t1_valid_one_cycle", 32'(m_valid), 32'd0);
        check("t1_frame_cnt", 32'(frame_cnt), 32'd1);

        // T2: two triples in order
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0); send_byte(8'hFF, 1'b0); send_byte(8'h00, 1'b0);
        drain();
        check("t2_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

        // T3: back-pressure with full FIFO
        m_ready = 1'b0;
        for (int i = 0; i < 9; i++) send_byte(8'($urandom), 1'b0);
        repeat (3) tick();
        check("t3_s_ready_held", 32'(s_ready), 32'd0);
        check("t3_m_valid", 32'(m_valid), 32'd1);
        check("t3_two_pushed", 32'(frame_cnt), 32'(exp_frames - 16'd1));
        m_ready = 1'b1;
        drain();
        check("t3_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

        // T4: sof mid-triple
        d0 = drop_seen;
        e0 = exp_drops;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b0);
        send_byte(8'h55, 1'b0);
        drain();
        check("t4_drop_pulses", 32'(drop_seen - d0), 32'(exp_drops - e0));
        check("t4_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

        // Randomized stream with random back-pressure and sof
        rand_ready = 1'b1;
        for (int i = 0; i < 180; i++) begin
            send_byte(8'($urandom), ($urandom_range(0, 7) == 0));
            repeat ($urandom_range(0, 2)) tick();
        end
        while (part_n != 0) send_byte(8'($urandom), 1'b0);
        rand_ready = 1'b0;
        m_ready = 1'b1;
        drain();
        check("rand_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
        check("rand_drops", 32'(drop_seen), 32'(exp_drops));

        // T6: async reset in C2 with one result queued
        m_ready = 1'b0;
        send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0); send_byte(8'h56, 1'b0);
        send_byte(8'h78, 1'b0); send_byte(8'h9A, 1'b0);
        tick();
        tick();
        check("t6_queued", 32'(m_valid), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_m_valid", 32'(m_valid), 32'd0);
        check("t6_frame_cnt", 32'(frame_cnt), 32'd0);
        check("t6_s_ready", 32'(s_ready), 32'd1);
        check("t6_drop", 32'(drop), 32'd0);
        exp_q.delete();
        part_n = 0;
        exp_frames = 16'd0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        m_ready = 1'b1;
        send_byte(8'hF0, 1'b0); send_byte(8'hCC, 1'b0); send_byte(8'hAA, 1'b0);
        drain();
        check("t6_after_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
        check("final_drops", 32'(drop_seen), 32'(exp_drops));
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        done = 1'b1;
    endtask

    initial begin
        fork
            monitor();
            run();
        join
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
